// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
package wb_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [REG_W-1:0] GPR_ZERO = '0;

  typedef struct packed {
    logic              fp;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic              bw;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending write-back entries; exposes all slots for hazard lookup.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             din,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      valid,
  output wb_entry_t [DEPTH-1:0] entries
);

  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  wb_entry_t [DEPTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    valid = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      valid[i] = (CW'(AW'(AW'(i) - rd_ptr)) < count);
    end
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU path with priority, queued producers via FIFO, starvation guard,
// registered register-file write port and a combinational pending-write hazard query.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AW         = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic              a_fp,
  input  logic [REG_W-1:0]  a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_byte,
  output logic              a_stall,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic              q_fp,
  input  logic [REG_W-1:0]  q_reg,
  input  logic [DATA_W-1:0] q_data,
  input  logic              q_byte,
  output logic [REG_W-1:0]  wreg,
  output logic [DATA_W-1:0] wdata,
  output logic              w_byte,
  output logic              gpr_w_en,
  output logic              fpr_w_en,
  input  logic              chk_fp,
  input  logic [REG_W-1:0]  chk_reg,
  output logic              chk_busy,
  output logic [AW:0]       count
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  wb_entry_t             a_entry;
  wb_entry_t             q_entry;
  wb_entry_t             head;
  wb_entry_t             sel_entry;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  a_win;
  logic                  sel;
  logic [SW-1:0]         starve;
  logic [SW-1:0]         starve_nxt;

  assign a_entry = '{fp: a_fp, rd: a_reg, data: a_data, bw: a_byte};
  assign q_entry = '{fp: q_fp, rd: q_reg, data: q_data, bw: q_byte};

  assign q_ready   = !rst && !full;
  assign push      = q_valid && q_ready;
  assign a_win     = !a_stall && a_valid;
  assign pop       = !a_win && !empty;
  assign sel       = a_win || pop;
  assign sel_entry = a_win ? a_entry : head;

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .din     (q_entry),
    .pop     (pop),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .valid   (valid),
    .entries (entries)
  );

  // Count ALU wins that bypass a non-empty queue; any drain resets the streak.
  always_comb begin
    starve_nxt = starve;
    if (pop || empty) begin
      starve_nxt = '0;
    end else if (a_win && (starve != SW'(STARVE_MAX))) begin
      starve_nxt = starve + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve   <= '0;
      a_stall  <= 1'b0;
      wreg     <= '0;
      wdata    <= '0;
      w_byte   <= 1'b0;
      gpr_w_en <= 1'b0;
      fpr_w_en <= 1'b0;
    end else begin
      starve   <= starve_nxt;
      a_stall  <= (starve_nxt == SW'(STARVE_MAX));
      gpr_w_en <= sel && !sel_entry.fp && (sel_entry.rd != GPR_ZERO);
      fpr_w_en <= sel && sel_entry.fp;
      if (sel) begin
        wreg   <= sel_entry.rd;
        wdata  <= sel_entry.data;
        w_byte <= sel_entry.bw;
      end
    end
  end

  // Pending writes live in the queue, the output stage, or the push accepted this cycle.
  always_comb begin
    chk_busy = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid[i] && (entries[i].fp == chk_fp) && (entries[i].rd == chk_reg)) chk_busy = 1'b1;
    end
    if (gpr_w_en && !chk_fp && (wreg == chk_reg)) chk_busy = 1'b1;
    if (fpr_w_en && chk_fp && (wreg == chk_reg))  chk_busy = 1'b1;
    if (push && (q_fp == chk_fp) && (q_reg == chk_reg)) chk_busy = 1'b1;
    if (!chk_fp && (chk_reg == GPR_ZERO)) chk_busy = 1'b0;
  end

endmodule
